// File: rtl/adc_mon_pkg.sv
// Shared constants for the ADC monitor scheduler: FSM encoding, mode values, default width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package adc_mon_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_ACCUM  = 2'd2;
  localparam logic [1:0] ST_EMIT   = 2'd3;

  localparam logic MODE_DDS = 1'b0;
  localparam logic MODE_CW  = 1'b1;

  localparam int DATA_W_DEFAULT = 16;
endpackage

// File: rtl/adc_monitor_scheduler_snapshot_sync.sv
// Snapshot capture of averages/peaks for the I2C side, merged requests, frozen while a read is busy.
// Latency: snap_valid 2 cycles after snap_req (idle bus) or 2 cycles after i2c_busy falls.
// Backpressure: i2c_busy holds requests pending; outputs never change while busy is high.
module snapshot_sync
  import adc_mon_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snap_req,
  input  logic              i2c_busy,
  input  logic [DATA_W-1:0] dds_avg,
  input  logic [DATA_W-1:0] cw_avg,
  input  logic [DATA_W-1:0] dds_peak,
  input  logic [DATA_W-1:0] cw_peak,
  output logic [DATA_W-1:0] snap_dds_avg,
  output logic [DATA_W-1:0] snap_cw_avg,
  output logic [DATA_W-1:0] snap_dds_peak,
  output logic [DATA_W-1:0] snap_cw_peak,
  output logic              snap_valid
);
  logic pending;
  logic busy_q;
  logic copy;

  // Copy only after the bus has been idle for a full cycle, so a read that just
  // ended never sees its registers move underneath it.
  assign copy = pending & ~i2c_busy & ~busy_q;

  // Pending flag, busy history, snapshot registers and completion strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= 1'b0;
      busy_q        <= 1'b0;
      snap_valid    <= 1'b0;
      snap_dds_avg  <= '0;
      snap_cw_avg   <= '0;
      snap_dds_peak <= '0;
      snap_cw_peak  <= '0;
    end else begin
      pending    <= snap_req | (pending & ~copy);
      busy_q     <= i2c_busy;
      snap_valid <= copy;
      if (copy) begin
        snap_dds_avg  <= dds_avg;
        snap_cw_avg   <= cw_avg;
        snap_dds_peak <= dds_peak;
        snap_cw_peak  <= cw_peak;
      end
    end
  end
endmodule

// File: rtl/adc_monitor_scheduler.sv
// Sequences DDS/CW ADC measurement: settle discard, windowed average, per-mode peaks, snapshots.
// Latency: avg_valid one cycle after the final window sample; snapshot per snapshot_sync.
// Backpressure: none on samples (every sample_valid is taken); enable low aborts the window.
module adc_monitor_scheduler
  import adc_mon_pkg::*;
#(
  parameter int AVG_LOG2       = 3,
  parameter int SETTLE_SAMPLES = 2,
  parameter int DATA_W         = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode_req,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              peak_clear,
  input  logic              snap_req,
  input  logic              i2c_busy,
  output logic              mode_sel,
  output logic              avg_valid,
  output logic              avg_mode,
  output logic [DATA_W-1:0] avg_value,
  output logic [DATA_W-1:0] snap_dds_avg,
  output logic [DATA_W-1:0] snap_cw_avg,
  output logic [DATA_W-1:0] snap_dds_peak,
  output logic [DATA_W-1:0] snap_cw_peak,
  output logic              snap_valid
);
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN = CNT_W'(1) << AVG_LOG2;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_SAMPLES);

  logic [1:0]        state, state_n;
  logic              mode_n;
  logic              acc_take, acc_fresh, settle_take, settle_load, win_last;
  logic [3:0]        settle_cnt;
  logic [SUM_W-1:0]  sum, sum_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] avg_dds, avg_cw, peak_dds, peak_cw;

  // Next state, applied mode and what this cycle's sample is used for.
  always_comb begin
    state_n     = state;
    mode_n      = mode_sel;
    acc_take    = 1'b0;
    acc_fresh   = 1'b0;
    settle_take = 1'b0;
    settle_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          mode_n      = mode_req;
          settle_load = 1'b1;
          state_n     = (SETTLE_SAMPLES == 0) ? ST_ACCUM : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (sample_valid) begin
          settle_take = 1'b1;
          if (settle_cnt == 4'd1) state_n = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_take = sample_valid;
      end
      default: begin
        // Window boundary: a sample here starts the next window unless the mode switches.
        acc_fresh = 1'b1;
        state_n   = ST_ACCUM;
        if (mode_req != mode_sel) begin
          mode_n      = mode_req;
          settle_load = 1'b1;
          if (SETTLE_SAMPLES != 0) begin
            state_n = ST_SETTLE;
            if (sample_valid) begin
              settle_take = 1'b1;
              if (SETTLE_SAMPLES == 1) state_n = ST_ACCUM;
            end
          end else begin
            acc_take = sample_valid;
          end
        end else begin
          acc_take = sample_valid;
        end
      end
    endcase
    sum_n    = acc_fresh ? SUM_W'(sample_data) : sum + SUM_W'(sample_data);
    cnt_n    = acc_fresh ? CNT_W'(1) : cnt + CNT_W'(1);
    win_last = (cnt_n == WIN);
    if (acc_take && win_last) state_n = ST_EMIT;
    if (!enable) begin
      state_n     = ST_IDLE;
      mode_n      = mode_sel;
      acc_take    = 1'b0;
      settle_take = 1'b0;
      settle_load = 1'b0;
    end
  end

  // FSM state and applied mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_sel <= MODE_DDS;
    end else begin
      state    <= state_n;
      mode_sel <= mode_n;
    end
  end

  // Settle counter; a sample arriving on the load cycle already counts as discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= 4'd0;
    end else if (settle_load) begin
      settle_cnt <= settle_take ? SETTLE_LD - 4'd1 : SETTLE_LD;
    end else if (settle_take) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // Window accumulator; cleared on abort, mode change or after each emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      cnt <= '0;
    end else if (acc_take) begin
      sum <= sum_n;
      cnt <= cnt_n;
    end else if (!enable || settle_load || state == ST_EMIT) begin
      sum <= '0;
      cnt <= '0;
    end
  end

  // Average output strobe and the per-mode average store on the cycle leaving EMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_valid <= 1'b0;
      avg_mode  <= MODE_DDS;
      avg_value <= '0;
      avg_dds   <= '0;
      avg_cw    <= '0;
    end else begin
      avg_valid <= acc_take & win_last;
      if (acc_take && win_last) begin
        avg_value <= DATA_W'(sum_n >> AVG_LOG2);
        avg_mode  <= mode_n;
      end
      if (state == ST_EMIT) begin
        if (mode_sel == MODE_CW) avg_cw <= avg_value;
        else                     avg_dds <= avg_value;
      end
    end
  end

  // Per-mode peaks; a clear on the same cycle as a sample wins.
  always_ff @(posedge clk) begin
    if (rst || peak_clear) begin
      peak_dds <= '0;
      peak_cw  <= '0;
    end else if (acc_take) begin
      if (mode_n == MODE_CW) begin
        if (sample_data > peak_cw) peak_cw <= sample_data;
      end else begin
        if (sample_data > peak_dds) peak_dds <= sample_data;
      end
    end
  end

  snapshot_sync #(.DATA_W(DATA_W)) u_snap (
    .clk          (clk),
    .rst          (rst),
    .snap_req     (snap_req),
    .i2c_busy     (i2c_busy),
    .dds_avg      (avg_dds),
    .cw_avg       (avg_cw),
    .dds_peak     (peak_dds),
    .cw_peak      (peak_cw),
    .snap_dds_avg (snap_dds_avg),
    .snap_cw_avg  (snap_cw_avg),
    .snap_dds_peak(snap_dds_peak),
    .snap_cw_peak (snap_cw_peak),
    .snap_valid   (snap_valid)
  );
endmodule

// File: tb/tb_adc_monitor_scheduler.sv
// Bench for adc_monitor_scheduler: directed test-plan cases then randomized traffic.
// Latency: checks avg_valid/snap_valid cycle-exactly against a sample-stream reference model.
// Backpressure: exercises i2c_busy gating of snapshots.
module tb_adc_monitor_scheduler;
  localparam int AL  = 3;
  localparam int ST  = 2;
  localparam int DW  = 16;
  localparam int WIN = 1 << AL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, mode_req, sample_valid, peak_clear, snap_req, i2c_busy;
  logic [DW-1:0] sample_data;
  logic          mode_sel, avg_valid, avg_mode, snap_valid;
  logic [DW-1:0] avg_value, snap_dds_avg, snap_cw_avg, snap_dds_peak, snap_cw_peak;

  adc_monitor_scheduler #(.AVG_LOG2(AL), .SETTLE_SAMPLES(ST), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode_req(mode_req),
    .sample_valid(sample_valid), .sample_data(sample_data), .peak_clear(peak_clear),
    .snap_req(snap_req), .i2c_busy(i2c_busy), .mode_sel(mode_sel),
    .avg_valid(avg_valid), .avg_mode(avg_mode), .avg_value(avg_value),
    .snap_dds_avg(snap_dds_avg), .snap_cw_avg(snap_cw_avg),
    .snap_dds_peak(snap_dds_peak), .snap_cw_peak(snap_cw_peak), .snap_valid(snap_valid)
  );

  typedef struct { int v; int m; int c; } avg_exp_t;
  typedef struct { int da; int ca; int dp; int cp; int c; } snap_exp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  avg_exp_t  aq[$];
  snap_exp_t sq[$];

  // Reference model state: the stream of accepted samples, not the FSM.
  bit m_idle = 1'b1, m_bnd = 1'b0, m_pend = 1'b0, m_busy_prev = 1'b0, m_copy;
  int m_settle = 0, m_mode = 0, m_last = 0, m_sum;
  int m_win[$];
  int m_avg[2]  = '{0, 0};
  int m_peak[2] = '{0, 0};
  bit e_busy = 1'b0, e_rst = 1'b1;

  // Values seen by the monitor, used by directed checks.
  int n_avg = 0, last_avg_v = 0, last_avg_m = 0;
  int prev_snap[4] = '{0, 0, 0, 0};

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(int v);
    sample_valid = 1'b1;
    sample_data  = DW'(v);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic samp_n(int v, int n);
    for (int i = 0; i < n; i++) samp(v);
  endtask

  task automatic wait_snap(string name, int exp_lat);
    int k;
    k = 0;
    while (k < 10 && !snap_valid) begin
      tick();
      k++;
    end
    check(name, k, exp_lat);
  endtask

  task automatic check_all_zero();
    check("rst_mode_sel", mode_sel, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_avg_mode", avg_mode, 0);
    check("rst_avg_value", avg_value, 0);
    check("rst_snap_dds_avg", snap_dds_avg, 0);
    check("rst_snap_cw_avg", snap_cw_avg, 0);
    check("rst_snap_dds_peak", snap_dds_peak, 0);
    check("rst_snap_cw_peak", snap_cw_peak, 0);
    check("rst_snap_valid", snap_valid, 0);
  endtask

  // Reference model: evaluated on each rising edge with the inputs of the cycle just ending.
  always @(posedge clk) begin
    cyc++;
    e_busy = i2c_busy;
    e_rst  = rst;
    if (rst) begin
      m_idle = 1'b1; m_bnd = 1'b0; m_settle = 0; m_win.delete();
      m_mode = 0; m_last = 0; m_avg = '{0, 0}; m_peak = '{0, 0};
      m_pend = 1'b0; m_busy_prev = 1'b0;
    end else begin
      m_copy = m_pend && !i2c_busy && !m_busy_prev;
      if (m_copy) sq.push_back(snap_exp_t'{m_avg[0], m_avg[1], m_peak[0], m_peak[1], cyc});
      m_pend      = snap_req || (m_pend && !m_copy);
      m_busy_prev = i2c_busy;
      if (m_bnd) m_avg[m_mode] = m_last;
      if (!enable) begin
        m_idle = 1'b1; m_bnd = 1'b0; m_win.delete();
      end else if (m_idle) begin
        m_idle = 1'b0; m_mode = int'(mode_req); m_settle = ST;
      end else begin
        if (m_bnd) begin
          m_bnd = 1'b0;
          if (int'(mode_req) != m_mode) begin
            m_mode = int'(mode_req);
            m_settle = ST;
          end
        end
        if (sample_valid) begin
          if (m_settle > 0) m_settle--;
          else begin
            m_win.push_back(int'(sample_data));
            if (int'(sample_data) > m_peak[m_mode]) m_peak[m_mode] = int'(sample_data);
            if (m_win.size() == WIN) begin
              m_sum = 0;
              foreach (m_win[i]) m_sum += m_win[i];
              m_last = m_sum / WIN;
              aq.push_back(avg_exp_t'{m_last, m_mode, cyc});
              m_bnd = 1'b1;
              m_win.delete();
            end
          end
        end
      end
      if (peak_clear) m_peak = '{0, 0};
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("mode_sel", mode_sel, m_mode);
      if (avg_valid) begin
        check("avg_has_expectation", int'(aq.size() > 0), 1);
        if (aq.size() > 0) begin
          avg_exp_t e;
          e = aq.pop_front();
          check("avg_value", avg_value, e.v);
          check("avg_mode", avg_mode, e.m);
          check("avg_cycle", cyc, e.c);
          n_avg++;
          last_avg_v = int'(avg_value);
          last_avg_m = int'(avg_mode);
        end
      end else if (aq.size() > 0 && aq[0].c <= cyc) begin
        check("avg_valid_when_due", avg_valid, 1);
        void'(aq.pop_front());
      end
      if (snap_valid) begin
        check("snap_has_expectation", int'(sq.size() > 0), 1);
        if (sq.size() > 0) begin
          snap_exp_t s;
          s = sq.pop_front();
          check("snap_dds_avg", snap_dds_avg, s.da);
          check("snap_cw_avg", snap_cw_avg, s.ca);
          check("snap_dds_peak", snap_dds_peak, s.dp);
          check("snap_cw_peak", snap_cw_peak, s.cp);
          check("snap_cycle", cyc, s.c);
        end
      end else if (sq.size() > 0 && sq[0].c <= cyc) begin
        check("snap_valid_when_due", snap_valid, 1);
        void'(sq.pop_front());
      end
      if (e_busy && !e_rst) begin
        check("busy_freeze_dds_avg", snap_dds_avg, prev_snap[0]);
        check("busy_freeze_cw_avg", snap_cw_avg, prev_snap[1]);
        check("busy_freeze_dds_peak", snap_dds_peak, prev_snap[2]);
        check("busy_freeze_cw_peak", snap_cw_peak, prev_snap[3]);
      end
      prev_snap = '{int'(snap_dds_avg), int'(snap_cw_avg), int'(snap_dds_peak), int'(snap_cw_peak)};
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; mode_req = 1'b0; sample_valid = 1'b0; sample_data = '0;
    peak_clear = 1'b0; snap_req = 1'b0; i2c_busy = 1'b0;
    tick(); tick();
    check_all_zero();
    rst = 1'b0;
    tick();

    // Basic average: 100,101 discarded, (102..109)>>3 = 105.
    enable = 1'b1;
    tick();
    for (int v = 100; v <= 109; v++) samp(v);
    tick();
    check("basic_avg", last_avg_v, 105);
    check("basic_mode", last_avg_m, 0);
    check("basic_count", n_avg, 1);

    // Truncation: seven zeros and a 7 average to 0.
    samp_n(0, 7); samp(7); tick();
    check("trunc_avg", last_avg_v, 0);
    // Full-scale samples must not overflow the sum.
    samp_n(16'hFFFF, 8); tick();
    check("fullscale_avg", last_avg_v, 65535);

    // Mode switch mid-window only applies at the boundary.
    samp_n(10, 3);
    mode_req = 1'b1;
    samp_n(10, 5);
    check("mode_hold_mid_window", mode_sel, 0);
    tick();
    check("mode_after_emit", mode_sel, 1);
    samp_n(1, 2);
    samp_n(50, 8);
    mode_req = 1'b0; i2c_busy = 1'b1; snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check("cw_avg", last_avg_v, 50);
    check("cw_mode", last_avg_m, 1);

    // Snapshot held off by busy while the DDS average updates to 200.
    samp_n(200, 10);
    tick(); tick(); tick();
    check("avg200_count", n_avg, 6);
    check("avg200_value", last_avg_v, 200);
    check("busy_snap_frozen", snap_dds_avg, 0);
    i2c_busy = 1'b0;
    wait_snap("busy_release_latency", 2);
    check("busy_release_dds_avg", snap_dds_avg, 200);

    // Peak clear beats a coincident sample; back-to-back samples both land.
    peak_clear = 1'b1; samp(500); peak_clear = 1'b0;
    samp(300); samp(400);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    wait_snap("snap_req_latency", 1);
    check("peak_dds_after_clear", snap_dds_peak, 400);
    check("peak_cw_after_clear", snap_cw_peak, 0);
    check("snap_cw_avg_kept", snap_cw_avg, 50);

    // Abort after 5 window samples: no average, stored averages hold.
    samp_n(7, 2);
    enable = 1'b0;
    tick(); tick(); tick();
    check("abort_no_avg", n_avg, 6);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    wait_snap("abort_snap_latency", 1);
    check("abort_avg_held", snap_dds_avg, 200);

    // Reset mid-window clears every output.
    enable = 1'b1; mode_req = 1'b1;
    tick();
    samp_n(33, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    check_all_zero();
    check("rst_no_avg", n_avg, 6);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      sample_valid = ($urandom % 10) < 6;
      sample_data  = ($urandom % 8 == 0) ? 16'hFFFF : DW'($urandom);
      if ($urandom % 50 == 0) mode_req = ~mode_req;
      if ($urandom % 150 == 0) enable = 1'b0;
      else if (!enable && $urandom % 4 == 0) enable = 1'b1;
      peak_clear = ($urandom % 40 == 0);
      snap_req   = ($urandom % 15 == 0);
      if ($urandom % 25 == 0) i2c_busy = ~i2c_busy;
      rst = ($urandom % 700 == 0);
      tick();
    end

    // Drain: flush one final snapshot and let pending strobes appear.
    rst = 1'b0; sample_valid = 1'b0; peak_clear = 1'b0; i2c_busy = 1'b0; enable = 1'b0;
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    repeat (20) tick();
    check("avg_queue_drained", aq.size(), 0);
    check("snap_queue_drained", sq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_monitor_scheduler.md
# adc_monitor_scheduler

Sequences the current-monitor ADC path between DDS and CW measurement modes and produces windowed averages and per-mode peaks from the raw ADC sample stream. Sits between the ADC capture block and the I2C register file. Drives the mode select that the ADC limit checker uses. Serves snapshot requests from the I2C side without tearing while an I2C read is in progress.

## Interface
Parameters:
- AVG_LOG2, 3: window length is 2^AVG_LOG2 samples, legal range 0..6.
- SETTLE_SAMPLES, 2: samples discarded after every mode change, legal range 0..15.
- DATA_W, 16: sample width.

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run scheduling. Low aborts the current window.
- mode_req  in  1  requested mode: 0 = DDS, 1 = CW.
- sample_valid  in  1  one-cycle strobe from the ADC capture block.
- sample_data  in  DATA_W  ADC sample, qualified by sample_valid.
- peak_clear  in  1  pulse that clears both peak registers.
- snap_req  in  1  pulse from I2C requesting a snapshot.
- i2c_busy  in  1  I2C read in progress. Snapshot registers are frozen while high.
- mode_sel  out  1  applied mode, drives the limit checker mode select.
- avg_valid  out  1  one-cycle strobe.
- avg_mode  out  1  mode of the window that produced avg_value.
- avg_value  out  DATA_W  window average.
- snap_dds_avg, snap_cw_avg, snap_dds_peak, snap_cw_peak  out  DATA_W each  snapshot registers.
- snap_valid  out  1  one-cycle strobe, asserted when the snapshot registers update.

## Operation
State machine: IDLE, SETTLE, ACCUM, EMIT.

- **IDLE**
  - enable=1 → latch mode_req into mode_sel.
  - Load settle counter with SETTLE_SAMPLES.
  - Go to SETTLE, or directly to ACCUM if SETTLE_SAMPLES=0.
- **SETTLE**
  - Each sample_valid decrements the settle counter. The sample is discarded.
  - Counter at 1 when a sample arrives → go to ACCUM.
- **ACCUM**
  - On sample_valid: sum += sample_data. Sum width is DATA_W+AVG_LOG2, so it never overflows.
  - On sample_valid: sample count += 1, and the per-mode peak for mode_sel = max(peak, sample).
  - The 2^AVG_LOG2-th sample → go to EMIT.
- **EMIT** (one cycle)
  - avg_value = sum >> AVG_LOG2 (truncating).
  - Store it into the internal per-mode average register selected by mode_sel.
  - Compare mode_req with mode_sel:
    - Different → update mode_sel and go to SETTLE.
    - Same → go to ACCUM.
  - A sample_valid during EMIT is the first sample of the next window when staying in ACCUM. It is a discarded settle sample when switching.
- **Mode changes** take effect only in IDLE or EMIT. mode_req toggling mid-window has no effect until the boundary.
- **enable=0** in any state → IDLE on the next cycle.
  - Partial sum and counts are discarded.
  - Averages, peaks and mode_sel hold.
- **Snapshot**
  - snap_req sets a pending flag. Multiple requests merge into one.
  - Pending and i2c_busy=0 → copy the four internal registers (pre-update values if EMIT or peak_clear occurs the same cycle) into the snap_* outputs.
  - Then pulse snap_valid and clear pending.
  - While i2c_busy=1, the snap_* outputs never change.
- **peak_clear**
  - Zeroes both peaks.
  - A sample updating a peak in the same cycle loses: the peak ends at 0.

## Timing
- **Reset values:** all outputs 0. State IDLE, pending clear, internal averages and peaks 0.
- **avg_valid** is high exactly one cycle, the cycle after the clock edge that accepted the final window sample (latency 1). avg_mode and avg_value are valid in that same cycle and hold until the next avg_valid.
- **mode_sel** changes only on the edge leaving IDLE or EMIT.
- **snap_valid**
  - High one cycle after the edge where the copy occurs.
  - Fastest response is snap_req at cycle N, with i2c_busy=0, → snap_valid at N+2.
  - If busy, snap_valid occurs 2 cycles after i2c_busy falls.
- **rst mid-window** discards everything. No avg_valid is produced for the aborted window.
- Back-to-back sample_valid on consecutive cycles must be accepted without loss.

## Structure
- Shared package `adc_mon_pkg` holds:
  - state encoding constants;
  - MODE_DDS=0 and MODE_CW=1;
  - default DATA_W.
- One natural sub-module: `snapshot_sync`, containing the pending flag, busy gating and snapshot registers. The FSM and accumulator stay in the top module.

## Test plan
- **Basic average:** AVG_LOG2=3, SETTLE_SAMPLES=2, mode_req=0, samples 100..109 → first two discarded. avg_value = (102+…+109)>>3 = 105, avg_mode=0, avg_valid one cycle after sample 109.
- **Mode switch:** mode_req to 1 mid-window → mode_sel stays 0 until EMIT, then 1. The next two samples are discarded and the following window reports avg_mode=1.
- **Truncation/width:** 8 samples of 0xFFFF → avg_value=0xFFFF. Samples 0,0,0,0,0,0,0,7 → avg_value=0.
- **Snapshot under busy:** i2c_busy=1, snap_req pulse, avg updates to 200 → snap_dds_avg unchanged. Release busy → snap_valid 2 cycles later with snap_dds_avg=200.
- **Abort/reset:** enable low after 5 samples → no avg_valid, internal averages hold. rst mid-window → all outputs 0.
- **Peak edge cases:** peak_clear coincident with sample 500 → peak 0. Back-to-back sample_valid 300, 400 → peak 400, both counted.
